// File: rtl/cp0_exception_if.sv
// CP0 access bundle between the M stage and the coprocessor-0 unit.
// The M stage drives requests; CP0 returns the redirect, EPC and mfc0 data.
interface cp0_exception_if;
    logic [4:0]  A;
    logic [31:0] DIn;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcCode;
    logic [5:0]  HWInt;
    logic        We;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    modport master (
        output A, DIn, PC, BD, ExcCode, HWInt, We, EXLClr,
        input  IntReq, EPC, DOut
    );

    modport slave (
        input  A, DIn, PC, BD, ExcCode, HWInt, We, EXLClr,
        output IntReq, EPC, DOut
    );
endinterface

// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 registers (SR, Cause, EPC, PRId) and exception/interrupt arbiter.
// Every input describes the instruction currently in M.
module cp0_exception_unit #(
    parameter logic [31:0] PRID_VALUE = 32'h4B58_4800
) (
    input  logic           clk,
    input  logic           rst_n,
    cp0_exception_if.slave bus
);
    localparam logic [0:0] NORMAL  = 1'b0;
    localparam logic [0:0] HANDLER = 1'b1;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    logic [5:0]  im;
    logic [0:0]  exl;
    logic        ie;
    logic        cause_bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_pend;
    logic        exc_pend;
    logic        int_req;
    logic [31:0] victim;
    logic [31:0] epc_next;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign int_pend = ie && (exl == NORMAL) && |(bus.HWInt & im);
    assign exc_pend = (exl == NORMAL) && (bus.ExcCode != 5'd0);
    assign int_req  = rst_n && (int_pend || exc_pend);

    // A delay-slot victim restarts at its branch, one word earlier.
    assign victim   = {bus.PC[31:2], 2'b00};
    assign epc_next = bus.BD ? victim - 32'd4 : victim;

    assign sr_word    = {16'd0, im, 8'd0, exl, ie};
    assign cause_word = {cause_bd, 15'd0, ip, 3'd0, exc_code, 2'd0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im       <= 6'd0;
            exl      <= NORMAL;
            ie       <= 1'b0;
            cause_bd <= 1'b0;
            ip       <= 6'd0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            ip <= bus.HWInt;
            if (int_req) begin
                exl      <= HANDLER;
                cause_bd <= bus.BD;
                exc_code <= int_pend ? 5'd0 : bus.ExcCode;
                epc      <= epc_next;
            end else if (bus.EXLClr) begin
                exl <= NORMAL;
            end else if (bus.We) begin
                case (bus.A)
                    REG_SR: begin
                        im  <= bus.DIn[15:10];
                        exl <= bus.DIn[1:1];
                        ie  <= bus.DIn[0];
                    end
                    REG_EPC: epc <= {bus.DIn[31:2], 2'b00};
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.DOut = 32'd0;
        case (bus.A)
            REG_SR:    bus.DOut = sr_word;
            REG_CAUSE: bus.DOut = cause_word;
            REG_EPC:   bus.DOut = epc;
            REG_PRID:  bus.DOut = PRID_VALUE;
            default:   bus.DOut = 32'd0;
        endcase
    end

    assign bus.IntReq = int_req;
    assign bus.EPC    = epc;
endmodule

// File: tb/tb_cp0_exception_unit.sv
// Bench for cp0_exception_unit: word-level reference model checked every cycle
// plus directed literal expectations from the register and request rules.
module tb_cp0_exception_unit;
    localparam logic [31:0] PRID = 32'h4B58_4800;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    cp0_exception_if bus ();

    cp0_exception_unit #(.PRID_VALUE(PRID)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state held as whole architectural words.
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    function automatic logic m_int();
        return m_sr[0] && !m_sr[1] && ((bus.HWInt & m_sr[15:10]) != 6'd0);
    endfunction

    function automatic logic m_req();
        return rst_n && (m_int() || (!m_sr[1] && bus.ExcCode != 5'd0));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd12) return m_sr;
        if (a == 5'd13) return m_cause;
        if (a == 5'd14) return m_epc;
        if (a == 5'd15) return PRID;
        return 32'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sr    <= 32'd0;
            m_cause <= 32'd0;
            m_epc   <= 32'd0;
        end else begin
            logic [31:0] c;
            logic [31:0] pc_al;
            c = m_cause;
            c[15:10] = bus.HWInt;
            pc_al = bus.PC & 32'hFFFF_FFFC;
            if (m_req()) begin
                m_sr    <= m_sr | 32'd2;
                c[31]   = bus.BD;
                c[6:2]  = m_int() ? 5'd0 : bus.ExcCode;
                m_epc   <= bus.BD ? pc_al - 32'd4 : pc_al;
            end else if (bus.EXLClr) begin
                m_sr <= m_sr & ~32'd2;
            end else if (bus.We && bus.A == 5'd12) begin
                m_sr <= bus.DIn & 32'h0000_FC03;
            end else if (bus.We && bus.A == 5'd14) begin
                m_epc <= bus.DIn & 32'hFFFF_FFFC;
            end
            m_cause <= c;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.We      = 1'b0;
        bus.EXLClr  = 1'b0;
        bus.ExcCode = 5'd0;
        bus.BD      = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.We  = 1'b1;
        bus.A   = a;
        bus.DIn = d;
        step();
        bus.We  = 1'b0;
    endtask

    task automatic rd(input string name, input logic [4:0] a,
                      input logic [31:0] exp);
        bus.A = a;
        #1;
        chk(name, bus.DOut, exp);
    endtask

    task automatic eret();
        bus.EXLClr = 1'b1;
        step();
        bus.EXLClr = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.A = 5'd15;
        bus.DIn = 32'd0;
        bus.PC = 32'd0;
        bus.HWInt = 6'd0;
        idle();

        fork
            forever begin
                @(negedge clk);
                chk("cyc_intreq", {31'd0, bus.IntReq}, {31'd0, m_req()});
                chk("cyc_epc", bus.EPC, m_epc);
                chk("cyc_dout", bus.DOut, m_read(bus.A));
            end
        join_none

        step();
        step();
        rd("rst_prid", 5'd15, PRID);
        chk("rst_intreq", {31'd0, bus.IntReq}, 32'd0);
        rst_n = 1'b1;
        step();

        // Asynchronous reset in mid-cycle with SR fully populated.
        mtc0(5'd12, 32'h0000_FC03);
        rd("sr_full", 5'd12, 32'h0000_FC03);
        neg();
        rst_n = 1'b0;
        #1;
        rd("arst_sr", 5'd12, 32'd0);
        rd("arst_cause", 5'd13, 32'd0);
        rd("arst_epc", 5'd14, 32'd0);
        chk("arst_epc_out", bus.EPC, 32'd0);
        chk("arst_intreq", {31'd0, bus.IntReq}, 32'd0);
        rd("arst_prid", 5'd15, PRID);
        step();
        rst_n = 1'b1;
        step();

        // Interrupt entry.
        mtc0(5'd12, 32'h0000_0401);
        bus.HWInt = 6'b000001;
        bus.PC    = 32'h0000_3010;
        #1;
        chk("irq_req", {31'd0, bus.IntReq}, 32'd1);
        step();
        chk("irq_drop", {31'd0, bus.IntReq}, 32'd0);
        rd("irq_sr", 5'd12, 32'h0000_0403);
        rd("irq_cause", 5'd13, 32'h0000_0400);
        chk("irq_epc", bus.EPC, 32'h0000_3010);
        bus.HWInt = 6'd0;
        eret();
        mtc0(5'd12, 32'd0);

        // Exception in a delay slot with IE=0.
        bus.ExcCode = 5'd12;
        bus.BD      = 1'b1;
        bus.PC      = 32'h0000_3024;
        #1;
        chk("ov_req", {31'd0, bus.IntReq}, 32'd1);
        step();
        idle();
        rd("ov_cause", 5'd13, 32'h8000_0030);
        chk("ov_epc", bus.EPC, 32'h0000_3020);

        // eret with a pending enabled interrupt.
        bus.HWInt = 6'b000100;
        mtc0(5'd12, 32'h0000_1003);
        chk("eret_hold", {31'd0, bus.IntReq}, 32'd0);
        eret();
        rd("eret_sr", 5'd12, 32'h0000_1001);
        chk("eret_req", {31'd0, bus.IntReq}, 32'd1);
        step();
        rd("eret_cause", 5'd13, 32'h0000_1000);
        bus.HWInt = 6'd0;
        eret();

        // mtc0 to EPC loses against a simultaneous RI exception.
        bus.We      = 1'b1;
        bus.A       = 5'd14;
        bus.DIn     = 32'h1234_5677;
        bus.ExcCode = 5'd10;
        bus.PC      = 32'h0000_3000;
        step();
        idle();
        chk("sim_epc", bus.EPC, 32'h0000_3000);
        rd("sim_cause", 5'd13, 32'h0000_0028);
        eret();

        // Delay slot at PC 0 wraps.
        bus.ExcCode = 5'd4;
        bus.BD      = 1'b1;
        bus.PC      = 32'd0;
        step();
        idle();
        chk("wrap_epc", bus.EPC, 32'hFFFF_FFFC);
        eret();

        // Misaligned victim PC.
        bus.ExcCode = 5'd4;
        bus.PC      = 32'h0000_3013;
        step();
        idle();
        chk("mis_epc", bus.EPC, 32'h0000_3010);
        rd("mis_cause", 5'd13, 32'h0000_0010);
        eret();

        // Plain mtc0/mfc0 and ignored writes.
        mtc0(5'd14, 32'hABCD_0003);
        rd("mtc0_epc", 5'd14, 32'hABCD_0000);
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd("cause_ro", 5'd13, 32'h0000_0010);
        mtc0(5'd15, 32'hFFFF_FFFF);
        rd("prid_ro", 5'd15, PRID);
        mtc0(5'd7, 32'hFFFF_FFFF);
        rd("unimpl", 5'd7, 32'd0);
        rd("sr_after", 5'd12, 32'h0000_1001);

        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cp0_exception_unit.md
# cp0_exception_unit

Coprocessor-0 register file and exception/interrupt arbiter for the P8 pipelined MIPS core. It consumes the decode-side CP0 control (`CP0Write` for mtc0, `eret`, plus exception codes derived from `RI`/`Ov`/`Ld`/`St`/`BD` and carried down the pipeline). It responds with the interrupt/exception request, the handler return address and mfc0 read data. It sits beside the M stage; every input refers to the instruction currently in M.

## Interface
- `PRID_VALUE`, default 32'h4B58_4800, read-only contents of PRId (reg 15).
- `clk` input 1, rising-edge clock.
- `rst_n` input 1, asynchronous active-low reset.
- `A` input 5, CP0 register index (rd field) for mtc0/mfc0.
- `DIn` input 32, mtc0 write data.
- `PC` input 32, PC of the M-stage instruction (victim PC).
- `BD` input 1, the M-stage instruction is in a branch delay slot.
- `ExcCode` input 5, pending synchronous exception code of the M-stage instruction; 0 means none. Codes used: 4 AdEL, 5 AdES, 10 RI, 12 Ov.
- `HWInt` input 6, external hardware interrupt lines, level-sensitive.
- `We` input 1, mtc0 write enable (`CP0Write`).
- `EXLClr` input 1, eret in M.
- `IntReq` output 1, flush the pipeline and redirect fetch to the handler at 32'h0000_4180.
- `EPC` output 32, current EPC register value, used as the eret target.
- `DOut` output 32, mfc0 read data, combinational on `A`.

## Operation
- **SR (reg 12).**
  - Implemented fields are IM[15:10], EXL[1] and IE[0].
  - All other bits read 0.
  - mtc0 writes only the implemented fields.
- **Cause (reg 13).**
  - Fields are BD[31], IP[15:10] and ExcCode[6:2]; all other bits read 0.
  - mtc0 to Cause is ignored.
  - IP is loaded from `HWInt` on every clock edge when reset is not asserted.
- **EPC (reg 14).**
  - mtc0 writes {DIn[31:2],2'b00}.
- **PRId (reg 15).**
  - Constant `PRID_VALUE`; writes are ignored.
- **Other indices.**
  - Reads return 0; writes are ignored.
- **Request logic (combinational).**
  - intPend = IE & ~EXL & |(HWInt & IM).
  - excPend = ~EXL & (ExcCode != 0).
  - IntReq = rst_n & (intPend | excPend).
  - Exceptions are taken regardless of IE.
- **State machine on SR.EXL.**
  - NORMAL (EXL=0) goes to HANDLER (EXL=1) on any edge where IntReq=1.
  - HANDLER goes to NORMAL on an edge with EXLClr=1.
  - mtc0 to SR may set or clear EXL directly.
- **On an IntReq edge.**
  - EXL <= 1 and Cause.BD <= BD.
  - Cause.ExcCode <= 0 if intPend, else ExcCode. Interrupt has priority over a simultaneous exception.
  - EPC <= BD ? {PC[31:2],2'b00} - 4 : {PC[31:2],2'b00}.
- **Same-edge priority:** IntReq > EXLClr > We. Only the highest-priority action updates SR/EPC; IP sampling always happens.
  - A mtc0 or eret in M while IntReq=1 is discarded, because that instruction is the victim.
- **DOut** reflects register contents before the edge. There is no write-through bypass; mtc0 followed by mfc0 of the same register returns the new value one cycle later.

## Timing
- **Reset (rst_n=0, asynchronous).**
  - SR=0, Cause=0, EPC=0.
  - IntReq=0; `EPC` output = 0.
  - `DOut` = PRID_VALUE if A=15, else 0.
- **Latency.** IntReq is combinational in the same cycle as the cause. State updates land on the next rising edge.
- **IntReq deassertion.** Once EXL=1, IntReq is 0 from the cycle after entry until EXL clears, with no nesting.
- **eret.** EXLClr at edge N clears EXL, so pending interrupts can raise IntReq in cycle N+1.
- **HWInt handling.** HWInt is not latched by this block; a line dropped before the request is taken loses the interrupt.
- **Wrap-around.** BD with PC=0 gives EPC=32'hFFFF_FFFC, modulo-2^32 wrap with no trap.
- **Misaligned PC.** A victim PC with nonzero [1:0] (AdEL fetch) is recorded with the low bits cleared.

## Test plan
- **Reset.** Assert rst_n=0 mid-cycle with prior SR=32'h0000_FC03 -> SR, Cause and EPC read 0 immediately and IntReq=0. Read A=15 -> 32'h4B58_4800.
- **Interrupt entry.**
  - Stimulus: mtc0 SR=32'h0000_0401, then HWInt=6'b000001, PC=32'h0000_3010, BD=0.
  - Response: IntReq=1 that cycle. Next cycle: SR=32'h0000_0403, Cause[6:2]=0, Cause[10]=1, EPC=32'h0000_3010, IntReq=0.
- **Exception in delay slot with interrupts disabled.**
  - Stimulus: IE=0, ExcCode=12, BD=1, PC=32'h0000_3024.
  - Response: IntReq=1. Next cycle: Cause=32'h8000_0030, EPC=32'h0000_3020.
- **eret.**
  - Stimulus: EXL=1 with HWInt[2]=1 and IM[12]=1 held; pulse EXLClr.
  - Response: EXL=0 after the edge, and IntReq=1 in the following cycle.
- **Simultaneous events.**
  - Stimulus: We=1, A=14, DIn=32'h1234_5677, with ExcCode=10, PC=32'h0000_3000.
  - Response: EPC=32'h0000_3000, not 32'h1234_5674; ExcCode field=10.
- **mtc0/mfc0.**
  - Stimulus: write A=14 with 32'hABCD_0003.
  - Response: a read next cycle gives 32'hABCD_0000. Writing A=13 or A=15 leaves their values unchanged.
